// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall controller for the 3-stage RV32I pipeline
// (IF, DE, MW). It produces operand forwarding selects, load-use stalls, branch
// flushes and pipeline-register holds. It also sequences the data-memory
// request/acknowledge handshake, with a timeout, and keeps a saturating
// stall-cycle counter.
//
// Build option: define LOAD_FWD_EN to forward load data straight from MW
// (select 10). With LOAD_FWD_EN undefined, a load hazard costs a one-cycle
// load-use stall plus a bubble into DE/MW.
module pipe_hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic [4:0]       i_de_rs1,
   input  logic [4:0]       i_de_rs2,
   input  logic             i_de_use_rs1,
   input  logic             i_de_use_rs2,
   input  logic             i_de_br_taken,
   input  logic [4:0]       i_mw_rd,
   input  logic             i_mw_reg_wr,
   input  logic             i_mw_rd_en,
   input  logic             i_mw_wr_en,
   input  logic [1:0]       i_mw_wb_sel,
   input  logic             i_dmem_ack,
   input  logic             i_cnt_clr,
   output logic             o_stall_if,
   output logic             o_stall_de,
   output logic             o_stall_mw,
   output logic             o_flush_de,
   output logic             o_bubble_mw,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b,
   output logic             o_dmem_req,
   output logic             o_bus_err,
   output logic             o_kill_mw,
   output logic [CNT_W-1:0] o_stall_cnt
);

   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [WAIT_W-1:0]   w_wait_nxt;
   logic [CNT_W-1:0]    r_stall_cnt;

   logic                w_access;
   logic                w_haz_a;
   logic                w_haz_b;
   logic [1:0]          w_fwd_a;
   logic [1:0]          w_fwd_b;
   logic                w_mem_stall;
   logic                w_req;
   logic                w_timeout;
   logic                w_luse;
   logic                w_stall_if;

   // A source hazards when DE reads a non-x0 register that MW is about to write.
   function automatic logic src_hazard(input logic use_s, input logic [4:0] rs,
                                       input logic reg_wr, input logic [4:0] rd);
      return use_s & reg_wr & (rd != 5'd0) & (rd == rs);
   endfunction

   // Map a hazard and the MW writeback source onto an operand-select code.
   function automatic logic [1:0] fwd_code(input logic haz, input logic [1:0] wb_sel);
      logic [1:0] code;
      code = 2'b00;
      if (haz) begin
         case (wb_sel)
            2'b00:   code = 2'b01;
            2'b01:   code = 2'b11;
`ifdef LOAD_FWD_EN
            2'b10:   code = 2'b10;
`else
            2'b10:   code = 2'b00;
`endif
            default: code = 2'b00;
         endcase
      end else begin
         code = 2'b00;
      end
      return code;
   endfunction

   assign w_access = i_mw_rd_en | i_mw_wr_en;
   assign w_haz_a  = src_hazard(i_de_use_rs1, i_de_rs1, i_mw_reg_wr, i_mw_rd);
   assign w_haz_b  = src_hazard(i_de_use_rs2, i_de_rs2, i_mw_reg_wr, i_mw_rd);
   assign w_fwd_a  = fwd_code(w_haz_a, i_mw_wb_sel);
   assign w_fwd_b  = fwd_code(w_haz_b, i_mw_wb_sel);

`ifdef LOAD_FWD_EN
   assign w_luse = 1'b0;
`else
   // Load data is only usable from the regfile once the load has completed;
   // the stall is taken in that completion cycle (no completion on timeout).
   logic w_load_haz;
   logic w_mem_done;
   assign w_load_haz = (w_haz_a | w_haz_b) & (i_mw_wb_sel == 2'b10);
   assign w_mem_done = (r_state == ST_RUN) ? (~w_access | i_dmem_ack) : i_dmem_ack;
   assign w_luse     = w_load_haz & w_mem_done;
`endif

   // Memory handshake next-state logic: request, wait stall and timeout detection.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_mem_stall = 1'b0;
      w_req       = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_access) begin
               w_req = 1'b1;
               if (i_dmem_ack) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_MEM_WAIT;
                  w_wait_nxt  = {WAIT_W{1'b0}};
                  w_mem_stall = 1'b1;
               end
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            w_req = 1'b1;
            if (i_dmem_ack) begin
               w_state_nxt = ST_RUN;
               w_wait_nxt  = {WAIT_W{1'b0}};
            end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_RUN;
               w_wait_nxt  = {WAIT_W{1'b0}};
            end else begin
               w_wait_nxt  = r_wait_cnt + WAIT_W'(1'b1);
               w_mem_stall = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_wait_nxt  = {WAIT_W{1'b0}};
         end
      endcase
   end

   // State and wait-counter registers.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= {WAIT_W{1'b0}};
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   assign w_stall_if = w_mem_stall | w_luse;

   // Saturating stall-cycle counter; clear wins over increment.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_stall_cnt <= {CNT_W{1'b0}};
      end else if (i_cnt_clr) begin
         r_stall_cnt <= {CNT_W{1'b0}};
      end else if (w_stall_if && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1'b1);
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   // Combinational outputs are forced low while reset is held.
   assign o_stall_if  = i_rstn & w_stall_if;
   assign o_stall_de  = i_rstn & w_stall_if;
   assign o_stall_mw  = i_rstn & w_mem_stall;
   assign o_bubble_mw = i_rstn & w_luse;
   assign o_flush_de  = i_rstn & i_de_br_taken & ~w_stall_if;
   assign o_fwd_a     = i_rstn ? w_fwd_a : 2'b00;
   assign o_fwd_b     = i_rstn ? w_fwd_b : 2'b00;
   assign o_dmem_req  = i_rstn & w_req;
   assign o_bus_err   = i_rstn & w_timeout;
   assign o_kill_mw   = i_rstn & w_timeout;
   assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4). Each cycle the
// stimulus pushes the hand-derived expected outputs to a scoreboard queue; a
// negedge process pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rstn;
   logic [4:0] i_de_rs1, i_de_rs2, i_mw_rd;
   logic       i_de_use_rs1, i_de_use_rs2, i_de_br_taken;
   logic       i_mw_reg_wr, i_mw_rd_en, i_mw_wr_en;
   logic [1:0] i_mw_wb_sel;
   logic       i_dmem_ack, i_cnt_clr;
   logic       o_stall_if, o_stall_de, o_stall_mw, o_flush_de, o_bubble_mw;
   logic [1:0] o_fwd_a, o_fwd_b;
   logic       o_dmem_req, o_bus_err, o_kill_mw;
   logic [3:0] o_stall_cnt;

`ifdef LOAD_FWD_EN
   localparam logic [1:0] FB_LOAD = 2'b10;
   localparam logic       LU      = 1'b0;
`else
   localparam logic [1:0] FB_LOAD = 2'b00;
   localparam logic       LU      = 1'b1;
`endif

   typedef struct {
      string      tag;
      logic [11:0] vec;
      logic [3:0]  cnt;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] exp_cnt  = 4'd0;

   always #5 i_clk = ~i_clk;

   pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_de_rs1(i_de_rs1), .i_de_rs2(i_de_rs2),
      .i_de_use_rs1(i_de_use_rs1), .i_de_use_rs2(i_de_use_rs2),
      .i_de_br_taken(i_de_br_taken),
      .i_mw_rd(i_mw_rd), .i_mw_reg_wr(i_mw_reg_wr),
      .i_mw_rd_en(i_mw_rd_en), .i_mw_wr_en(i_mw_wr_en), .i_mw_wb_sel(i_mw_wb_sel),
      .i_dmem_ack(i_dmem_ack), .i_cnt_clr(i_cnt_clr),
      .o_stall_if(o_stall_if), .o_stall_de(o_stall_de), .o_stall_mw(o_stall_mw),
      .o_flush_de(o_flush_de), .o_bubble_mw(o_bubble_mw),
      .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
      .o_dmem_req(o_dmem_req), .o_bus_err(o_bus_err), .o_kill_mw(o_kill_mw),
      .o_stall_cnt(o_stall_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected control vector: {sif,sde,smw,flush,bubble,fwd_a,fwd_b,req,err,kill}
   function automatic logic [11:0] e(input logic sif, input logic sde, input logic smw,
                                     input logic fl, input logic bub, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic req, input logic err,
                                     input logic kill);
      return {sif, sde, smw, fl, bub, fa, fb, req, err, kill};
   endfunction

   task automatic set_de(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic br);
      i_de_rs1 = rs1; i_de_rs2 = rs2; i_de_use_rs1 = u1; i_de_use_rs2 = u2; i_de_br_taken = br;
   endtask

   task automatic set_mw(input logic [4:0] rd, input logic reg_wr, input logic rd_en,
                         input logic wr_en, input logic [1:0] wb_sel);
      i_mw_rd = rd; i_mw_reg_wr = reg_wr; i_mw_rd_en = rd_en; i_mw_wr_en = wr_en;
      i_mw_wb_sel = wb_sel;
   endtask

   // Drive one cycle, push its expectation, advance the expected stall count.
   task automatic cyc(input string tag, input logic ack, input logic clr, input logic [11:0] expv);
      exp_t x;
      i_dmem_ack = ack;
      i_cnt_clr  = clr;
      if (!i_rstn) exp_cnt = 4'd0;
      x.tag = tag; x.vec = expv; x.cnt = exp_cnt;
      sb_q.push_back(x);
      if (!i_rstn || clr) exp_cnt = 4'd0;
      else if (expv[11] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      @(posedge i_clk);
      #1;
   endtask

   // Store access (no regfile write) that times out, or is acked in the last cycle.
   task automatic do_timeout(input string tag, input logic ack_last);
      set_de(5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      set_mw(5'd0, 1'b0, 1'b0, 1'b1, 2'b00);
      for (int k = 0; k < 4; k++) cyc({tag, "_w"}, 1'b0, 1'b0, e(1,1,1,0,0,2'b00,2'b00,1,0,0));
      if (ack_last) cyc({tag, "_ack"}, 1'b1, 1'b0, e(0,0,0,0,0,2'b00,2'b00,1,0,0));
      else          cyc({tag, "_err"}, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b00,1,1,1));
      set_mw(5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      cyc({tag, "_run"}, 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b00,0,0,0));
   endtask

   // Scoreboard: compare DUT outputs away from the active edge.
   always @(negedge i_clk) begin
      if (sb_q.size() > 0) begin : pop_blk
         exp_t x;
         x = sb_q.pop_front();
         check_eq({x.tag, "/ctl"},
                  {20'd0, o_stall_if, o_stall_de, o_stall_mw, o_flush_de, o_bubble_mw,
                   o_fwd_a, o_fwd_b, o_dmem_req, o_bus_err, o_kill_mw},
                  {20'd0, x.vec});
         check_eq({x.tag, "/cnt"}, {28'd0, o_stall_cnt}, {28'd0, x.cnt});
      end
   end

   initial begin
      i_rstn = 1'b0;
      i_dmem_ack = 1'b0; i_cnt_clr = 1'b0;
      set_de(5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
      set_mw(5'd5, 1'b1, 1'b1, 1'b0, 2'b00);
      @(posedge i_clk); #1;
      cyc("reset", 1'b0, 1'b0, 12'h000);
      i_rstn = 1'b1;

      // Forwarding patterns
      set_mw(5'd5, 1'b1, 1'b0, 1'b0, 2'b00); set_de(5'd5, 5'd6, 1'b1, 1'b1, 1'b0);
      cyc("alu_fwd", 1'b0, 1'b0, e(0,0,0,0,0,2'b01,2'b00,0,0,0));
      set_mw(5'd0, 1'b1, 1'b0, 1'b0, 2'b00); set_de(5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      cyc("x0", 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b00,0,0,0));
      set_mw(5'd1, 1'b1, 1'b0, 1'b0, 2'b01); set_de(5'd2, 5'd1, 1'b1, 1'b1, 1'b0);
      cyc("pc4", 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b11,0,0,0));
      set_mw(5'd5, 1'b1, 1'b0, 1'b0, 2'b00); set_de(5'd5, 5'd5, 1'b0, 1'b1, 1'b0);
      cyc("use_off", 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b01,0,0,0));
      set_mw(5'd5, 1'b1, 1'b0, 1'b0, 2'b11); set_de(5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
      cyc("wb11", 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b00,0,0,0));
      set_mw(5'd5, 1'b0, 1'b0, 1'b0, 2'b00);
      cyc("no_regwr", 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b00,0,0,0));
      set_de(5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      cyc("flush", 1'b0, 1'b0, e(0,0,0,1,0,2'b00,2'b00,0,0,0));

      // Zero-wait and 3-cycle memory access
      set_de(5'd1, 5'd2, 1'b1, 1'b1, 1'b0); set_mw(5'd0, 1'b0, 1'b0, 1'b1, 2'b00);
      cyc("zw", 1'b1, 1'b1, e(0,0,0,0,0,2'b00,2'b00,1,0,0));
      for (int k = 0; k < 3; k++) cyc("mw3_w", 1'b0, 1'b0, e(1,1,1,0,0,2'b00,2'b00,1,0,0));
      cyc("mw3_ack", 1'b1, 1'b0, e(0,0,0,0,0,2'b00,2'b00,1,0,0));
      set_mw(5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      cyc("mw3_idle", 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b00,0,0,0));

      // Timeout, then ack in the timeout cycle
      do_timeout("to", 1'b0);
      do_timeout("to_ack", 1'b1);

      // Load-use, zero-wait load
      set_mw(5'd7, 1'b1, 1'b1, 1'b0, 2'b10); set_de(5'd3, 5'd7, 1'b1, 1'b1, 1'b0);
      cyc("lu_zw", 1'b1, 1'b0, e(LU,LU,0,0,LU,2'b00,FB_LOAD,1,0,0));
      set_mw(5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      cyc("lu_next", 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b00,0,0,0));

      // Load-use after a 2-cycle wait
      set_mw(5'd7, 1'b1, 1'b1, 1'b0, 2'b10);
      cyc("lu_w0", 1'b0, 1'b0, e(1,1,1,0,0,2'b00,FB_LOAD,1,0,0));
      cyc("lu_w1", 1'b0, 1'b0, e(1,1,1,0,0,2'b00,FB_LOAD,1,0,0));
      cyc("lu_ack", 1'b1, 1'b0, e(LU,LU,0,0,LU,2'b00,FB_LOAD,1,0,0));
      set_mw(5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      cyc("lu_idle", 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b00,0,0,0));

      // Branch deferred by a memory stall
      set_de(5'd0, 5'd0, 1'b0, 1'b0, 1'b1); set_mw(5'd0, 1'b0, 1'b0, 1'b1, 2'b00);
      cyc("br_w0", 1'b0, 1'b0, e(1,1,1,0,0,2'b00,2'b00,1,0,0));
      cyc("br_w1", 1'b0, 1'b0, e(1,1,1,0,0,2'b00,2'b00,1,0,0));
      cyc("br_ack", 1'b1, 1'b0, e(0,0,0,1,0,2'b00,2'b00,1,0,0));
      set_de(5'd0, 5'd0, 1'b0, 1'b0, 1'b0); set_mw(5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      cyc("br_idle", 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b00,0,0,0));

      // Drive the counter into saturation, then clear while stalled
      for (int k = 0; k < 4; k++) do_timeout("sat", 1'b0);
      set_mw(5'd0, 1'b0, 1'b0, 1'b1, 2'b00);
      cyc("clr_pri", 1'b0, 1'b1, e(1,1,1,0,0,2'b00,2'b00,1,0,0));
      cyc("clr_ack", 1'b1, 1'b0, e(0,0,0,0,0,2'b00,2'b00,1,0,0));

      // Reset in the middle of a memory wait
      set_de(5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      cyc("rmw_run", 1'b0, 1'b0, e(1,1,1,0,0,2'b00,2'b00,1,0,0));
      i_rstn = 1'b0;
      cyc("rmw_rst", 1'b0, 1'b0, 12'h000);
      i_rstn = 1'b1;
      set_de(5'd0, 5'd0, 1'b0, 1'b0, 1'b0); set_mw(5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      cyc("rmw_idle", 1'b0, 1'b0, e(0,0,0,0,0,2'b00,2'b00,0,0,0));

      @(negedge i_clk); #1;
      check_eq("sb_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
